seg7_state_display: RTL and testbench

- Output-side counterpart of the switch input register: takes the 32-bit registered state word and shows it on the board's multiplexed common-anode seven-segment display as hex digits.
- Also mirrors state[15:0] onto the 16 LEDs.
- Latches a shadow copy on a load strobe and scans one digit at a time with a refresh divider.
- Provides optional leading-zero blanking and anti-ghosting blank time.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/hex_to_seg7.sv | 16 +
 rtl/seg7_state_display.sv | 136 +++++++++++++
 tb/tb_seg7_state_display.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_pkg : shared constants for the seven-segment state display    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package seg7_pkg;

    // Segment vectors are ordered {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Glyphs for 0..F, stored with entry 15 in the top slot.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Board variants: a 4-digit or an 8-digit display.
    localparam int NUM_DIGITS_SMALL = 4;
    localparam int NUM_DIGITS_LARGE = 8;

    function automatic logic is_legal_num_digits(input int n);
        return (n == NUM_DIGITS_SMALL) || (n == NUM_DIGITS_LARGE);
    endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hex_to_seg7 : 4-bit nibble to active-low seven-segment glyph       |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule : hex_to_seg7
`default_nettype wire

// File: rtl/seg7_state_display.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_state_display : shadows a 32-bit state word, scans it as hex  |
// | onto a multiplexed common-anode display and mirrors it on LEDs.    |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module seg7_state_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           state,
    input  logic                  load,
    input  logic                  lz_blank,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [15:0]           led,
    output logic                  frame_done
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SHOW_W = 4 * NUM_DIGITS;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [31:0]           r_shadow;
    logic [NUM_DIGITS-1:0] r_dp_shadow;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [IDX_W-1:0]      r_digit_idx;

    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic                  r_frame_done;

    logic [NUM_DIGITS-1:0] w_upper_zero;
    logic [3:0]            w_nibble;
    logic                  w_dp_bit;
    logic                  w_upper_zero_sel;
    logic                  w_suppress;
    logic                  w_in_blank;
    logic                  w_wrap;
    logic [6:0]            w_seg_hex;

    // w_upper_zero[i]: every digit from i up to the most significant is 0.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_upper_zero
        assign w_upper_zero[i] = (r_shadow[SHOW_W-1:4*i] == '0);
    end

    if (BLANK_CYCLES > 0) begin : g_blank
        assign w_in_blank = (r_div_cnt < DIV_W'(BLANK_CYCLES));
    end else begin : g_no_blank
        assign w_in_blank = 1'b0;
    end

    always_comb begin
        w_nibble         = 4'h0;
        w_dp_bit         = 1'b0;
        w_upper_zero_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == IDX_W'(i)) begin
                w_nibble         = r_shadow[4*i +: 4];
                w_dp_bit         = r_dp_shadow[i];
                w_upper_zero_sel = w_upper_zero[i];
            end
        end
    end

    // Digit 0 is exempt so an all-zero word still shows a single "0".
    assign w_suppress = lz_blank && (r_digit_idx != '0) && w_upper_zero_sel;
    assign w_wrap     = (r_div_cnt == DIV_LAST);

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (w_nibble),
        .seg    (w_seg_hex)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow    <= '0;
            r_dp_shadow <= '0;
        end else if (load) begin
            r_shadow    <= state;
            r_dp_shadow <= dp_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_cnt    <= '0;
            r_digit_idx  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap && (r_digit_idx == IDX_LAST);
            if (w_wrap) begin
                r_div_cnt   <= '0;
                r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + 1'b1;
            end else begin
                r_div_cnt   <= r_div_cnt + 1'b1;
            end
        end
    end

    // Display drive is registered from the pre-edge scan position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an  <= '1;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else if (w_in_blank) begin
            r_an  <= '1;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~(NUM_DIGITS'(1) << r_digit_idx);
            r_seg <= w_suppress ? SEG_OFF : w_seg_hex;
            r_dp  <= ~w_dp_bit;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign led        = r_shadow[15:0];
    assign frame_done = r_frame_done;

endmodule : seg7_state_display
`default_nettype wire

// File: tb/tb_seg7_state_display.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seg7_state_display : randomized bench with a behavioural model  |
// | Revision              : 1.0                                        |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_seg7_state_display;

    localparam int ND = 8;
    localparam int RD = 4;
    localparam int BL = 1;

    localparam logic [6:0] REF_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   state;
    logic          load;
    logic          lz_blank;
    logic [ND-1:0] dp_mask;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;
    logic [15:0]   led;
    logic          frame_done;

    always #5 clk = ~clk;

    seg7_state_display #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (state),
        .load       (load),
        .lz_blank   (lz_blank),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .led        (led),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: time since reset release determines the scan position.
    int            elapsed = 0;
    logic [31:0]   m_shadow;
    logic [ND-1:0] m_dp;
    logic          model_valid = 1'b0;
    logic [ND-1:0] exp_an;
    logic [6:0]    exp_seg;
    logic          exp_dp;
    logic [15:0]   exp_led;
    logic          exp_fd;

    always @(posedge clk) begin
        if (!rst_n) begin
            model_valid = 1'b1;
            m_shadow    = '0;
            m_dp        = '0;
            elapsed     = 0;
            exp_an      = '1;
            exp_seg     = 7'h7F;
            exp_dp      = 1'b1;
            exp_fd      = 1'b0;
            exp_led     = '0;
        end else begin
            int          phase;
            int          digit;
            logic [31:0] upper;
            phase = elapsed % RD;
            digit = (elapsed / RD) % ND;
            if (phase < BL) begin
                exp_an  = '1;
                exp_seg = 7'h7F;
                exp_dp  = 1'b1;
            end else begin
                upper   = m_shadow >> (4 * digit);
                exp_an  = ~(ND'(1) << digit);
                exp_dp  = ~m_dp[digit];
                if (lz_blank && digit != 0 && upper == 0)
                    exp_seg = 7'h7F;
                else
                    exp_seg = REF_HEX[upper[3:0]];
            end
            exp_fd = ((elapsed % (RD * ND)) == RD * ND - 1);
            if (load) begin
                m_shadow = state;
                m_dp     = dp_mask;
            end
            exp_led = m_shadow[15:0];
            elapsed++;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("an", 32'(an), 32'(exp_an));
            check("seg", 32'(seg), 32'(exp_seg));
            check("dp", 32'(dp), 32'(exp_dp));
            check("led", 32'(led), 32'(exp_led));
            check("frame_done", 32'(frame_done), 32'(exp_fd));
        end
    end

    task automatic wait_digit(input int d);
        logic [ND-1:0] target;
        int n;
        target = ~(ND'(1) << d);
        n = 0;
        @(negedge clk);
        while (exp_an !== target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_digit digit=%0d actual=timeout required=lit", d);
        end
    endtask

    task automatic do_load(input logic [31:0] v, input logic [ND-1:0] m);
        state   = v;
        dp_mask = m;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    localparam logic [6:0] SCAN_SEG [8] = '{
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    initial begin
        int fd_count;
        int lit_wait;
        rst_n    = 1'b0;
        state    = 32'hFFFF_FFFF;
        load     = 1'b1;
        lz_blank = 1'b0;
        dp_mask  = '1;
        repeat (3) @(negedge clk);
        check("reset_an", 32'(an), 32'h0000_00FF);
        check("reset_seg", 32'(seg), 32'h0000_007F);
        check("reset_dp", 32'(dp), 32'h1);
        check("reset_led", 32'(led), 32'h0);

        load  = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("led_hold", 32'(led), 32'h0);

        // Scan order with decimal points on digits 0 and 2.
        do_load(32'h0123_4567, 8'h05);
        check("led_value", 32'(led), 32'h0000_4567);
        for (int d = 0; d < 8; d++) begin
            wait_digit(d);
            check("scan_seg", 32'(seg), 32'(SCAN_SEG[d]));
            check("scan_dp", 32'(dp), (d == 0 || d == 2) ? 32'h0 : 32'h1);
        end
        fd_count = 0;
        repeat (64) begin
            @(negedge clk);
            if (frame_done) fd_count++;
        end
        check("frame_count", 32'(fd_count), 32'd2);

        // Leading-zero blanking.
        lz_blank = 1'b1;
        do_load(32'h0000_00A0, 8'h00);
        for (int d = 0; d < 8; d++) begin
            wait_digit(d);
            check("lz_seg", 32'(seg),
                  (d == 0) ? 32'h40 : (d == 1) ? 32'h08 : 32'h7F);
        end
        lz_blank = 1'b0;
        wait_digit(5);
        check("nolz_seg", 32'(seg), 32'h40);

        lz_blank = 1'b1;
        do_load(32'h0, 8'h00);
        wait_digit(0);
        check("zero_d0", 32'(seg), 32'h40);
        wait_digit(4);
        check("zero_d4", 32'(seg), 32'h7F);

        // Mid-period load during digit 3.
        lz_blank = 1'b0;
        do_load(32'h0123_4567, 8'h00);
        wait_digit(3);
        check("mid_before", 32'(seg), 32'h19);
        do_load(32'hFFFF_FFFF, 8'h00);
        check("mid_same", 32'(seg), 32'h19);
        @(negedge clk);
        check("mid_after", 32'(seg), 32'h0E);
        check("mid_an", 32'(an), 32'hF7);

        // Reset mid-scan.
        wait_digit(5);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_an", 32'(an), 32'hFF);
        rst_n = 1'b1;
        lit_wait = 0;
        do begin
            @(negedge clk);
            lit_wait++;
        end while (an === '1 && lit_wait < 50);
        check("rst_first_wait", 32'(lit_wait), 32'(BL + 1));
        check("rst_first_an", 32'(an), 32'hFE);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            load     = ($urandom_range(0, 9) == 0);
            state    = $urandom >> (4 * $urandom_range(0, 8));
            lz_blank = 1'(($urandom));
            dp_mask  = ND'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b1;
        load  = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seg7_state_display
`default_nettype wire
